ecg_window_sequencer: RTL and testbench

//  Sequences windowed processing of the fetal-ECG sample stream.
//  - Fills a WINDOW_LEN-deep sample buffer, then starts the processing engine.
//  - Re-runs the engine up to MAX_ITER times, or until it reports convergence.
//  - Generates strided, wrap-around read addresses for the engine.
//  - Sits between the sample input front end and the iterative separation

---
 rtl/ecg_window_sequencer_if.sv | 35 +++
 rtl/ecg_window_sequencer.sv | 158 +++++++++++++++
 tb/tb_ecg_window_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecg_window_sequencer_if.sv
// Handshake bundle between the ECG sample front end, the window buffer and the separation engine.
// The master side drives the requests; the slave side is the window sequencer.
interface ecg_window_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int IT_W   = 6
);
    logic              start;
    logic              stop;
    logic              sample_valid;
    logic              sample_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              proc_start;
    logic              proc_done;
    logic              converged;
    logic              rd_req;
    logic [8:0]        rd_step;
    logic [ADDR_W-1:0] rd_addr;
    logic [IT_W-1:0]   iter_count;
    logic              busy;
    logic              window_done;
    logic              overrun;

    modport master (
        output start, stop, sample_valid, proc_done, converged, rd_req, rd_step,
        input  sample_ready, wr_en, wr_addr, proc_start, rd_addr, iter_count,
               busy, window_done, overrun
    );

    modport slave (
        input  start, stop, sample_valid, proc_done, converged, rd_req, rd_step,
        output sample_ready, wr_en, wr_addr, proc_start, rd_addr, iter_count,
               busy, window_done, overrun
    );
endinterface

// File: rtl/ecg_window_sequencer.sv
// Fills one sample window, then re-runs the separation engine on it until convergence
// or the iteration limit, handing the engine strided wrap-around read addresses.
module ecg_window_sequencer #(
    parameter int ADDR_W     = 9,
    parameter int WINDOW_LEN = 256,
    parameter int MAX_ITER   = 32,
    parameter int IT_W       = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ecg_window_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Stride arithmetic is one bit wider than the address so the sum never overflows.
    localparam int SW = (ADDR_W + 1 > 10) ? ADDR_W + 1 : 10;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WINDOW_LEN - 1);
    localparam logic [SW-1:0]     WIN_LEN   = SW'(WINDOW_LEN);
    localparam logic [IT_W-1:0]   ITER_MAX  = IT_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic              overrun_q, overrun_d;
    logic              stopPend_q, stopPend_d;

    logic              sampleReady;
    logic              wrAccept;
    logic [SW-1:0]     stepRaw;
    logic [SW-1:0]     stepEff;
    logic [SW-1:0]     rdSum;
    logic [ADDR_W-1:0] rdAddrNext;
    logic [IT_W-1:0]   iterNext;

    // A stop in FILL drops any sample offered in the same cycle.
    assign sampleReady = (state_q == ST_FILL);
    assign wrAccept    = bus.sample_valid & sampleReady & ~bus.stop;

    assign stepRaw = SW'(bus.rd_step);
    always_comb begin
        stepEff = stepRaw;
        if (stepRaw == '0) begin
            stepEff = SW'(1);
        end else if (stepRaw >= WIN_LEN) begin
            stepEff = WIN_LEN - SW'(1);
        end
    end

    // Both operands are below WINDOW_LEN, so one subtraction is enough to wrap.
    assign rdSum      = SW'(rdAddr_q) + stepEff;
    assign rdAddrNext = (rdSum >= WIN_LEN) ? ADDR_W'(rdSum - WIN_LEN) : ADDR_W'(rdSum);
    assign iterNext   = iter_q + IT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wrAddr_q   <= '0;
            rdAddr_q   <= '0;
            iter_q     <= '0;
            overrun_q  <= 1'b0;
            stopPend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrAddr_q   <= wrAddr_d;
            rdAddr_q   <= rdAddr_d;
            iter_q     <= iter_d;
            overrun_q  <= overrun_d;
            stopPend_q <= stopPend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wrAddr_d   = wrAddr_q;
        rdAddr_d   = rdAddr_q;
        iter_d     = iter_q;
        overrun_d  = overrun_q;
        stopPend_d = stopPend_q;

        if (bus.sample_valid && !sampleReady && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_FILL;
                    wrAddr_d  = '0;
                    iter_d    = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (bus.stop) begin
                    state_d  = ST_IDLE;
                    wrAddr_d = '0;
                end else if (wrAccept) begin
                    if (wrAddr_q == LAST_ADDR) begin
                        state_d  = ST_RUN;
                        wrAddr_d = '0;
                        rdAddr_d = '0;
                    end else begin
                        wrAddr_d = wrAddr_q + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_WAIT;
                if (bus.stop) stopPend_d = 1'b1;
            end
            ST_WAIT: begin
                if (bus.stop) stopPend_d = 1'b1;
                // Completion outranks a same-cycle read request.
                if (bus.proc_done) begin
                    iter_d = iterNext;
                    if (bus.converged || (iterNext == ITER_MAX)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                        rdAddr_d = '0;
                    end
                end else if (bus.rd_req) begin
                    rdAddr_d = rdAddrNext;
                end
            end
            ST_DONE: begin
                if (stopPend_q || bus.stop) begin
                    state_d    = ST_IDLE;
                    stopPend_d = 1'b0;
                end else begin
                    state_d  = ST_FILL;
                    wrAddr_d = '0;
                    iter_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sample_ready = sampleReady;
    assign bus.wr_en        = wrAccept;
    assign bus.wr_addr      = wrAddr_q;
    assign bus.proc_start   = (state_q == ST_RUN);
    assign bus.rd_addr      = rdAddr_q;
    assign bus.iter_count   = iter_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.window_done  = (state_q == ST_DONE);
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_ecg_window_sequencer.sv
// Randomised scenario bench for the window sequencer with an 8-sample window and 4 iterations max.
// Expected values come from a small arithmetic model of the window/iteration rules.
module tb_ecg_window_sequencer;
    localparam int ADDR_W = 9;
    localparam int WL     = 8;
    localparam int MI     = 4;
    localparam int IT_W   = 3;

    logic clk;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;
    int   expRd      = 0;

    ecg_window_sequencer_if #(.ADDR_W(ADDR_W), .IT_W(IT_W)) bus ();

    ecg_window_sequencer #(
        .ADDR_W(ADDR_W), .WINDOW_LEN(WL), .MAX_ITER(MI), .IT_W(IT_W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Effective stride from the rules: 0 reads as 1, anything past the window saturates.
    function automatic int effStep(input int s);
        if (s == 0) return 1;
        if (s >= WL) return WL - 1;
        return s;
    endfunction

    task automatic clearInputs();
        bus.start = 0; bus.stop = 0; bus.sample_valid = 0; bus.proc_done = 0;
        bus.converged = 0; bus.rd_req = 0; bus.rd_step = '0;
    endtask

    // From FILL: deliver WL samples (optionally with random gaps), then check the RUN cycle.
    task automatic do_fill(input bit gaps, input bit runSample);
        int accepted = 0;
        int cycles = 0;
        bit v;
        while (accepted < WL && cycles < 200) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.sample_valid = v;
            #1;
            checkCount++;
            if (bus.wr_en !== v || bus.wr_addr !== ADDR_W'(accepted)) begin
                $display("[TB] FAIL fill_write: wr_en=%0b wr_addr=%0d expected wr_en=%0b wr_addr=%0d",
                         bus.wr_en, bus.wr_addr, v, accepted);
            end else passCount++;
            tick();
            if (v) accepted++;
            cycles++;
        end
        bus.sample_valid = runSample;
        #1;
        checkCount++;
        if (bus.proc_start !== 1'b1 || bus.rd_addr !== '0 || bus.sample_ready !== 1'b0) begin
            $display("[TB] FAIL run_entry: proc_start=%0b rd_addr=%0d ready=%0b expected 1,0,0",
                     bus.proc_start, bus.rd_addr, bus.sample_ready);
        end else passCount++;
        tick();
        bus.sample_valid = 0;
        expRd = 0;
        #1;
        checkCount++;
        if (bus.proc_start !== 1'b0 || bus.busy !== 1'b1 || bus.overrun !== runSample) begin
            $display("[TB] FAIL wait_entry: proc_start=%0b busy=%0b overrun=%0b expected 0,1,%0b",
                     bus.proc_start, bus.busy, bus.overrun, runSample);
        end else passCount++;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n = 0;
        #3;
        checkCount++;
        if ({bus.busy, bus.sample_ready, bus.wr_en, bus.proc_start, bus.window_done, bus.overrun} !== 6'b0 ||
            bus.wr_addr !== '0 || bus.rd_addr !== '0 || bus.iter_count !== '0) begin
            $display("[TB] FAIL reset_state: busy=%0b ready=%0b wr_addr=%0d rd_addr=%0d iter=%0d expected all 0",
                     bus.busy, bus.sample_ready, bus.wr_addr, bus.rd_addr, bus.iter_count);
        end else passCount++;
        tick();
        rst_n = 1;
        tick();
        bus.stop = 1;
        tick();
        bus.stop = 0;
        #1;
        checkCount++;
        if (bus.busy !== 1'b0) begin
            $display("[TB] FAIL idle_stop: busy=%0b expected 0", bus.busy);
        end else passCount++;
    endtask

    task automatic test_fill();
        bus.start = 1;
        tick();
        bus.start = 0;
        #1;
        checkCount++;
        if (bus.sample_ready !== 1'b1 || bus.busy !== 1'b1) begin
            $display("[TB] FAIL fill_entry: ready=%0b busy=%0b expected 1,1", bus.sample_ready, bus.busy);
        end else passCount++;
        do_fill(1'b0, 1'b0);
    endtask

    task automatic test_stride();
        int s;
        for (int i = 0; i < 5; i++) begin
            bus.rd_req = 1; bus.rd_step = 9'd3;
            tick();
            expRd = (expRd + 3) % WL;
            checkCount++;
            if (bus.rd_addr !== ADDR_W'(expRd)) begin
                $display("[TB] FAIL stride3: rd_addr=%0d expected %0d", bus.rd_addr, expRd);
            end else passCount++;
        end
        for (int i = 0; i < 12; i++) begin
            s = (i == 0) ? 0 : int'($urandom_range(0, 20));
            bus.rd_req = 1'($urandom_range(0, 3) != 0) | (i == 0);
            bus.rd_step = 9'(s);
            tick();
            if (bus.rd_req) expRd = (expRd + effStep(s)) % WL;
            checkCount++;
            if (bus.rd_addr !== ADDR_W'(expRd)) begin
                $display("[TB] FAIL stride_rand: step=%0d rd_addr=%0d expected %0d", s, bus.rd_addr, expRd);
            end else passCount++;
        end
        bus.rd_req = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        checkCount++;
        if (bus.busy !== 1'b1 || bus.proc_start !== 1'b0 || bus.sample_ready !== 1'b0) begin
            $display("[TB] FAIL start_ignored: busy=%0b proc_start=%0b ready=%0b expected 1,0,0",
                     bus.busy, bus.proc_start, bus.sample_ready);
        end else passCount++;
    endtask

    task automatic test_max_iter();
        int pulses = 1;
        for (int k = 1; k <= MI; k++) begin
            bus.proc_done = 1; bus.converged = 0; bus.rd_req = (k == 1); bus.rd_step = 9'd2;
            tick();
            bus.proc_done = 0; bus.rd_req = 0;
            #1;
            if (k < MI) begin
                if (bus.proc_start === 1'b1) pulses++;
                checkCount++;
                if (bus.iter_count !== IT_W'(k) || bus.rd_addr !== '0) begin
                    $display("[TB] FAIL iter_run: iter=%0d rd_addr=%0d expected %0d,0", bus.iter_count, bus.rd_addr, k);
                end else passCount++;
                tick();
            end else begin
                checkCount++;
                if (bus.window_done !== 1'b1 || bus.iter_count !== IT_W'(MI) || pulses != MI) begin
                    $display("[TB] FAIL max_iter: done=%0b iter=%0d pulses=%0d expected 1,%0d,%0d",
                             bus.window_done, bus.iter_count, pulses, MI, MI);
                end else passCount++;
            end
        end
        tick();
        checkCount++;
        if (bus.window_done !== 1'b0 || bus.sample_ready !== 1'b1 || bus.iter_count !== '0) begin
            $display("[TB] FAIL refill: done=%0b ready=%0b iter=%0d expected 0,1,0",
                     bus.window_done, bus.sample_ready, bus.iter_count);
        end else passCount++;
    endtask

    task automatic test_converge();
        do_fill(1'b1, 1'b0);
        bus.converged = 1;
        tick();
        bus.converged = 0;
        bus.proc_done = 1;
        tick();
        bus.proc_done = 0;
        checkCount++;
        if (bus.proc_start !== 1'b1 || bus.iter_count !== IT_W'(1) || bus.window_done !== 1'b0) begin
            $display("[TB] FAIL conv_first: proc_start=%0b iter=%0d done=%0b expected 1,1,0",
                     bus.proc_start, bus.iter_count, bus.window_done);
        end else passCount++;
        tick();
        bus.proc_done = 1; bus.converged = 1;
        tick();
        bus.proc_done = 0; bus.converged = 0;
        checkCount++;
        if (bus.window_done !== 1'b1 || bus.iter_count !== IT_W'(2)) begin
            $display("[TB] FAIL converged: done=%0b iter=%0d expected 1,2", bus.window_done, bus.iter_count);
        end else passCount++;
        tick();
    endtask

    task automatic test_stop();
        for (int i = 0; i < 3; i++) begin
            bus.sample_valid = 1;
            tick();
        end
        bus.stop = 1;
        #1;
        checkCount++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== ADDR_W'(3)) begin
            $display("[TB] FAIL stop_fill_drop: wr_en=%0b wr_addr=%0d expected 0,3", bus.wr_en, bus.wr_addr);
        end else passCount++;
        tick();
        bus.stop = 0; bus.sample_valid = 0;
        checkCount++;
        if (bus.busy !== 1'b0 || bus.wr_addr !== '0 || bus.overrun !== 1'b0) begin
            $display("[TB] FAIL stop_fill_idle: busy=%0b wr_addr=%0d overrun=%0b expected 0,0,0",
                     bus.busy, bus.wr_addr, bus.overrun);
        end else passCount++;
        bus.start = 1;
        tick();
        bus.start = 0;
        do_fill(1'b0, 1'b0);
        bus.stop = 1;
        tick();
        bus.stop = 0;
        bus.proc_done = 1; bus.converged = 1;
        tick();
        bus.proc_done = 0; bus.converged = 0;
        checkCount++;
        if (bus.window_done !== 1'b1 || bus.busy !== 1'b1) begin
            $display("[TB] FAIL stop_wait_done: done=%0b busy=%0b expected 1,1", bus.window_done, bus.busy);
        end else passCount++;
        tick();
        checkCount++;
        if (bus.busy !== 1'b0 || bus.sample_ready !== 1'b0) begin
            $display("[TB] FAIL stop_wait_idle: busy=%0b ready=%0b expected 0,0", bus.busy, bus.sample_ready);
        end else passCount++;
    endtask

    task automatic test_overrun_reset();
        bus.start = 1;
        tick();
        bus.start = 0;
        do_fill(1'b0, 1'b1);
        bus.rd_req = 1; bus.rd_step = 9'd5;
        tick();
        tick();
        bus.rd_req = 0;
        #2;
        rst_n = 0;
        #1;
        checkCount++;
        if ({bus.busy, bus.proc_start, bus.window_done, bus.overrun, bus.sample_ready} !== 5'b0 ||
            bus.rd_addr !== '0 || bus.iter_count !== '0 || bus.wr_addr !== '0) begin
            $display("[TB] FAIL async_reset: busy=%0b overrun=%0b rd_addr=%0d expected 0,0,0",
                     bus.busy, bus.overrun, bus.rd_addr);
        end else passCount++;
        tick();
        rst_n = 1;
        tick();
        bus.start = 1;
        tick();
        bus.start = 0;
        do_fill(1'b1, 1'b1);
        bus.stop = 1;
        tick();
        bus.stop = 0; bus.proc_done = 1; bus.converged = 1;
        tick();
        bus.proc_done = 0; bus.converged = 0;
        tick();
        checkCount++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b1) begin
            $display("[TB] FAIL overrun_hold: busy=%0b overrun=%0b expected 0,1", bus.busy, bus.overrun);
        end else passCount++;
        bus.start = 1;
        tick();
        bus.start = 0;
        checkCount++;
        if (bus.overrun !== 1'b0 || bus.sample_ready !== 1'b1) begin
            $display("[TB] FAIL overrun_clear: overrun=%0b ready=%0b expected 0,1", bus.overrun, bus.sample_ready);
        end else passCount++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stride();
        test_max_iter();
        test_converge();
        bus.stop = 1;
        tick();
        bus.stop = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        test_stop();
        test_overrun_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
